// File: rtl/sprite_dma.sv
// sprite_dma: copies a 128-byte sprite attribute table from CPU-visible
// memory into sprite RAM. The copy can optionally wait for the next vblank
// rising edge.
//
// Optional feature macro: SPRITE_DMA_VBLANK_ABORT_EN. When it is defined, a
// vblank falling edge during a synced copy aborts that copy.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   vblank              vertical blank from video timing
//   cpu_wr/cpu_rd       one-cycle register strobes
//   cpu_addr            0 base lo, 1 base hi, 2 ctrl/status
//   cpu_data_in/out     register data (read data is registered)
//   src_addr/src_data   source memory port (1-cycle read latency)
//   spriteram_*         sprite RAM write port
//   busy, done_irq      armed/transferring flag, end-of-transfer pulse
module sprite_dma #(
  parameter int unsigned SPRITE_COUNT     = 32,
  parameter int unsigned BYTES_PER_SPRITE = 4,
  parameter int unsigned SRC_ADDR_WIDTH   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      vblank,
  input  logic                      cpu_wr,
  input  logic                      cpu_rd,
  input  logic [1:0]                cpu_addr,
  input  logic [7:0]                cpu_data_in,
  output logic [7:0]                cpu_data_out,
  output logic [SRC_ADDR_WIDTH-1:0] src_addr,
  input  logic [7:0]                src_data,
  output logic [6:0]                spriteram_addr,
  output logic [7:0]                spriteram_data_in,
  output logic                      spriteram_wr,
  output logic                      busy,
  output logic                      done_irq
);

  localparam int unsigned XFER_LEN = SPRITE_COUNT * BYTES_PER_SPRITE;
  localparam int unsigned CNT_W    = 7;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XFER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_XFER,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W:0]   cnt_inc;
  logic [15:0]      base_q;
  logic             vblank_q;
  logic             done_q;
  logic             aborted_q;
  logic             start_ok;
  logic             issue;
  logic             abort_c;
  logic             status_rd;
  logic             rise;

  assign rise      = vblank & ~vblank_q;
  assign cnt_inc   = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign status_rd = cpu_rd && (cpu_addr == 2'd2);

  // Source memory returns data one cycle after the address, which lines up
  // with the registered write strobe, so write data passes straight through.
  assign spriteram_data_in = spriteram_wr ? src_data : 8'h00;

`ifdef SPRITE_DMA_VBLANK_ABORT_EN
  logic sync_q;
  logic fall;
  assign fall = ~vblank & vblank_q;
`endif

  // Next-state logic and per-cycle control.
  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    abort_c  = 1'b0;
    issue    = 1'b0;
`ifdef SPRITE_DMA_VBLANK_ABORT_EN
    abort_c = sync_q && fall && ((state_q == S_XFER) || (state_q == S_DRAIN));
`endif
    case (state_q)
      S_IDLE: begin
        if (cpu_wr && (cpu_addr == 2'd2) && cpu_data_in[0]) begin
          start_ok = 1'b1;
          state_d  = cpu_data_in[1] ? S_ARM : S_XFER;
        end
      end
      S_ARM: begin
        if (rise) state_d = S_XFER;
      end
      S_XFER: begin
        if (abort_c) begin
          state_d = S_DONE;
        end else begin
          issue = 1'b1;
          if (cnt_q == LAST_CNT) state_d = S_DRAIN;
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and register file.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      base_q         <= '0;
      vblank_q       <= 1'b0;
      done_q         <= 1'b0;
      aborted_q      <= 1'b0;
      src_addr       <= '0;
      spriteram_addr <= '0;
      spriteram_wr   <= 1'b0;
      busy           <= 1'b0;
      done_irq       <= 1'b0;
      cpu_data_out   <= '0;
`ifdef SPRITE_DMA_VBLANK_ABORT_EN
      sync_q         <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      vblank_q <= vblank;
      busy     <= (state_d == S_ARM) || (state_d == S_XFER) || (state_d == S_DRAIN);
      done_irq <= (state_d == S_DONE);
      spriteram_wr <= issue;

      if (start_ok) begin
        cnt_q    <= '0;
        src_addr <= SRC_ADDR_WIDTH'(base_q);
`ifdef SPRITE_DMA_VBLANK_ABORT_EN
        sync_q   <= cpu_data_in[1];
`endif
      end

      // Issue count k now; its write lands next cycle at address k.
      if (issue) begin
        spriteram_addr <= cnt_q;
        cnt_q          <= cnt_inc[CNT_W-1:0];
        src_addr       <= SRC_ADDR_WIDTH'(base_q) + SRC_ADDR_WIDTH'(cnt_inc);
      end

      if (cpu_wr && !busy) begin
        if (cpu_addr == 2'd0) base_q[7:0]  <= cpu_data_in;
        if (cpu_addr == 2'd1) base_q[15:8] <= cpu_data_in;
      end

      // Sticky flags: a same-cycle set beats the clear.
      done_q    <= ((state_d == S_DONE) && (state_q != S_DONE)) ||
                   (done_q && !(status_rd || start_ok));
      aborted_q <= abort_c || (aborted_q && !(status_rd || start_ok));

      if (cpu_rd) begin
        case (cpu_addr)
          2'd0:    cpu_data_out <= base_q[7:0];
          2'd1:    cpu_data_out <= base_q[15:8];
          2'd2:    cpu_data_out <= {5'b0, aborted_q, done_q, busy};
          default: cpu_data_out <= 8'h00;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sprite_dma.sv
// Directed self-checking bench for sprite_dma.
module tb_sprite_dma;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vblank = 1'b0;
  logic        cpu_wr = 1'b0;
  logic        cpu_rd = 1'b0;
  logic [1:0]  cpu_addr = 2'd0;
  logic [7:0]  cpu_data_in = 8'h00;
  logic [7:0]  cpu_data_out;
  logic [15:0] src_addr;
  logic [7:0]  src_data = 8'h00;
  logic [6:0]  spriteram_addr;
  logic [7:0]  spriteram_data_in;
  logic        spriteram_wr;
  logic        busy;
  logic        done_irq;

  sprite_dma dut (
    .clk(clk), .reset(reset), .vblank(vblank),
    .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_addr(cpu_addr),
    .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out),
    .src_addr(src_addr), .src_data(src_data),
    .spriteram_addr(spriteram_addr), .spriteram_data_in(spriteram_data_in),
    .spriteram_wr(spriteram_wr), .busy(busy), .done_irq(done_irq)
  );

  always #5 clk = ~clk;

  // Source memory: byte = low byte of the address, one-cycle latency.
  always @(posedge clk) src_data <= src_addr[7:0];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write/irq logger, sampled mid-cycle.
  int         wr_n = 0;
  int         irq_n = 0;
  int         irq_cyc = -1;
  int         wr_cyc_log [2048];
  logic [6:0] wr_addr_log[2048];
  logic [7:0] wr_data_log[2048];
  always @(negedge clk) begin
    if (spriteram_wr && wr_n < 2048) begin
      wr_cyc_log[wr_n]  = cyc;
      wr_addr_log[wr_n] = spriteram_addr;
      wr_data_log[wr_n] = spriteram_data_in;
      wr_n = wr_n + 1;
    end
    if (done_irq) begin
      irq_n   = irq_n + 1;
      irq_cyc = cyc;
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to the middle of the next cycle (after the logger has run).
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic reg_wr(input logic [1:0] a, input logic [7:0] d);
    cpu_wr = 1'b1; cpu_addr = a; cpu_data_in = d;
    tick();
    cpu_wr = 1'b0; cpu_data_in = 8'h00;
  endtask

  task automatic reg_rd(input logic [1:0] a, output logic [7:0] d);
    cpu_rd = 1'b1; cpu_addr = a;
    tick();
    cpu_rd = 1'b0;
    d = cpu_data_out;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  // Check one complete transfer logged from index b, start/edge cycle t.
  task automatic check_xfer(input string tag, input int b, input int t, input logic [15:0] base);
    int errs;
    int n;
    n = wr_n - b;
    chk({tag, "_count"}, n, 128);
    if (n > 0) begin
      chk({tag, "_first_cyc"}, wr_cyc_log[b], t + 2);
      chk({tag, "_last_cyc"}, wr_cyc_log[b + n - 1], t + 129);
    end
    errs = 0;
    for (int k = 0; k < n && k < 128; k++) begin
      logic [15:0] a;
      a = base + 16'(k);
      if (wr_addr_log[b + k] !== 7'(k) || wr_data_log[b + k] !== a[7:0]) errs++;
    end
    chk({tag, "_bytes"}, errs, 0);
  endtask

  initial begin
    logic [7:0] d;
    int t;
    int b;
    int irq0;
    int guard;

    // Reset values.
    run(3);
    chk("rst_wr", spriteram_wr, 0);
    chk("rst_addr", spriteram_addr, 0);
    chk("rst_data", spriteram_data_in, 0);
    chk("rst_src", src_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_irq", done_irq, 0);
    chk("rst_cpu_out", cpu_data_out, 0);
    reset = 1'b0;
    tick();
    reg_rd(2'd2, d);
    chk("rst_status", d, 8'h00);

    // Unsynced copy with busy protection exercised mid-transfer.
    reg_wr(2'd0, 8'h00);
    reg_wr(2'd1, 8'h40);
    b = wr_n; irq0 = irq_n; t = cyc;
    reg_wr(2'd2, 8'h01);
    chk("u_busy_t1", busy, 1);
    chk("u_src_t1", src_addr, 16'h4000);
    run(15);
    reg_rd(2'd2, d);
    chk("u_status_mid", d, 8'h01);
    reg_wr(2'd0, 8'h55);
    reg_wr(2'd1, 8'h12);
    reg_wr(2'd2, 8'h01);
    while (cyc < t + 130) tick();
    chk("u_busy_end", busy, 0);
    chk("u_irq_end", done_irq, 1);
    run(10);
    check_xfer("u", b, t, 16'h4000);
    chk("u_irq_n", irq_n - irq0, 1);
    chk("u_irq_cyc", irq_cyc, t + 130);
    reg_rd(2'd2, d);
    chk("u_status_done", d, 8'h02);
    reg_rd(2'd2, d);
    chk("u_status_reread", d, 8'h00);
    reg_rd(2'd0, d);
    chk("u_base_lo_kept", d, 8'h00);
    reg_rd(2'd1, d);
    chk("u_base_hi_kept", d, 8'h40);
    reg_rd(2'd3, d);
    chk("reg3_zero", d, 8'h00);

    // Source address wrap.
    reg_wr(2'd0, 8'hC0);
    reg_wr(2'd1, 8'hFF);
    b = wr_n; t = cyc;
    reg_wr(2'd2, 8'h01);
    run(64);
    chk("w_src_byte64", src_addr, 16'h0000);
    run(80);
    check_xfer("w", b, t, 16'hFFC0);
    if (wr_n - b >= 65) begin
      chk("w_byte63", wr_data_log[b + 63], 8'hFF);
      chk("w_byte64", wr_data_log[b + 64], 8'h00);
    end else begin
      chk("w_short", wr_n - b, 128);
    end
    reg_rd(2'd2, d);

    // Synced start with vblank already high.
    reg_wr(2'd0, 8'h00);
    reg_wr(2'd1, 8'h40);
    vblank = 1'b1;
    tick();
    b = wr_n; irq0 = irq_n;
    reg_wr(2'd2, 8'h03);
    run(10);
    chk("s_no_wr_armed", wr_n - b, 0);
    chk("s_busy_armed", busy, 1);
    vblank = 1'b0;
    run(5);
    chk("s_no_wr_low", wr_n - b, 0);
    t = cyc;
    vblank = 1'b1;
    run(140);
    check_xfer("s", b, t, 16'h4000);
    chk("s_irq_n", irq_n - irq0, 1);
    chk("s_irq_cyc", irq_cyc, t + 130);
    reg_rd(2'd2, d);
    chk("s_status", d, 8'h02);

    // Reset mid-transfer.
    b = wr_n; irq0 = irq_n;
    reg_wr(2'd2, 8'h01);
    guard = 0;
    while (wr_n - b < 50 && guard < 300) begin tick(); guard++; end
    chk("r_reach50", wr_n - b, 50);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run(150);
    chk("r_no_more_wr", wr_n - b, 50);
    chk("r_busy", busy, 0);
    chk("r_no_irq", irq_n - irq0, 0);
    reg_rd(2'd2, d);
    chk("r_status", d, 8'h00);

    // vblank falls at write 40 of a synced transfer.
    vblank = 1'b0;
    tick();
    b = wr_n; irq0 = irq_n;
    reg_wr(2'd2, 8'h03);
    run(3);
    t = cyc;
    vblank = 1'b1;
    guard = 0;
    while (wr_n - b < 40 && guard < 300) begin tick(); guard++; end
    chk("a_reach40", wr_n - b, 40);
    vblank = 1'b0;
`ifdef SPRITE_DMA_VBLANK_ABORT_EN
    tick();
    chk("a_busy_c1", busy, 0);
    chk("a_irq_c1", done_irq, 1);
    run(150);
    chk("a_wr_count", wr_n - b, 40);
    chk("a_irq_n", irq_n - irq0, 1);
    reg_rd(2'd2, d);
    chk("a_status", d, 8'h06);
`else
    run(150);
    check_xfer("a", b, t, 16'h4000);
    chk("a_irq_n", irq_n - irq0, 1);
    reg_rd(2'd2, d);
    chk("a_status", d, 8'h02);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_dma.md
# sprite_dma

Sprite attribute DMA: the writer side of sprite RAM. On CPU command it copies a 128-byte sprite attribute table (32 sprites × 4 bytes) from CPU-visible memory into sprite RAM, which the sprite engine scans every line. The copy can optionally be synchronised to the start of vblank so the engine never renders a half-updated table.

## Interface

Parameters:
- `SPRITE_COUNT`, 32: sprites per table.
- `BYTES_PER_SPRITE`, 4: attribute bytes per sprite. Transfer length is `SPRITE_COUNT*BYTES_PER_SPRITE` = 128.
- `SRC_ADDR_WIDTH`, 16: width of the source memory address.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `vblank` in 1: vertical blank from the video timing block.
- `cpu_wr` in 1: register write strobe, one cycle.
- `cpu_rd` in 1: register read strobe, one cycle.
- `cpu_addr` in 2: register select. 0 = base low, 1 = base high, 2 = control/status.
- `cpu_data_in` in 8: register write data.
- `cpu_data_out` out 8: register read data, registered.
- `src_addr` out `SRC_ADDR_WIDTH`: source memory read address. Source memory has fixed 1-cycle read latency.
- `src_data` in 8: source memory read data.
- `spriteram_addr` out 7: sprite RAM write address.
- `spriteram_data_in` out 8: sprite RAM write data.
- `spriteram_wr` out 1: sprite RAM write enable.
- `busy` out 1: high while armed or transferring.
- `done_irq` out 1: one-cycle pulse when a transfer ends.

Sprite RAM byte layout, copied verbatim:
- byte 0: bit7 enable, [3:0] Y[11:8].
- byte 1: Y[7:0].
- byte 2: [7:3] image index, [2:0] X upper.
- byte 3: X[7:0].

## Operation

Registers:
- Reg 0 and reg 1 hold the 16-bit base address. Writes are ignored while `busy`.
- Reg 2 write: bit0 = start, bit1 = sync. Start is ignored while `busy`.
- Reg 2 read returns status: bit0 busy, bit1 done (sticky), bit2 aborted (sticky), other bits 0.
- Done and aborted clear on a reg 2 read and on an accepted start. Clear-on-read wins over a same-cycle set only if the read samples the old value, i.e. a set in the same cycle persists.
- Reads of reg 0/1 return the base bytes; reg 3 reads 0.

States:
- IDLE: on accepted start, go to ARM if sync = 1, else XFER. The counter loads 0 and `src_addr` loads base.
- ARM: wait for a vblank rising edge (`vblank` high, previous sample low). Then go to XFER. If vblank is already high at arm time, wait for the next rising edge.
- XFER: each cycle, `src_addr` = base + count (wraps modulo 2^`SRC_ADDR_WIDTH`) and count increments. The write stage is a one-cycle delayed copy: `spriteram_wr`=1, `spriteram_addr` = previous count, `spriteram_data_in` = `src_data`. After issuing count = 127, go to DRAIN.
- DRAIN: perform the final write (address 127), then go to DONE.
- DONE: deassert `busy`, set done, pulse `done_irq`, return to IDLE.

Rules:
- Bytes are never reordered or skipped. Sprite RAM address n receives source byte base+n.
- `spriteram_wr` is 0 in every state except the cycle after an XFER issue.

## Timing

- Reset values: `spriteram_wr`=0, `spriteram_addr`=0, `spriteram_data_in`=0, `src_addr`=0, `busy`=0, `done_irq`=0, `cpu_data_out`=0, base=0, done=aborted=0. State = IDLE.
- Unsynced start written in cycle T:
  - `busy`=1 from T+1.
  - First `spriteram_wr` at T+2 (address 0).
  - Last write at T+129 (address 127).
  - `busy`=0 and `done_irq`=1 at T+130.
- Synced start: the same sequence, with T replaced by the cycle in which the rising edge is detected.
- `cpu_data_out` is valid the cycle after `cpu_rd`.
- `reset` mid-transfer returns to IDLE. `spriteram_wr` is 0 from the following cycle, and no done/irq is generated.

## Configuration

- `SPRITE_DMA_VBLANK_ABORT_EN` defined:
  - In a synced transfer, a vblank falling edge detected in cycle C during XFER/DRAIN aborts the transfer.
  - No `spriteram_wr` is asserted from C+1 onward.
  - `busy`=0, aborted=1, done=1, and `done_irq` pulses at C+1.
- Undefined: vblank is ignored after ARM, transfers always complete, and status bit2 reads 0.

## Test plan

- **Unsynced copy:** base=0x4000, source bytes = address low byte, start=0x01 at T. Required: 128 writes at T+2..T+129 with data 0x00..0x7F, and `done_irq` at T+130.
- **Wrap:** base=0xFFC0. Byte 64 must come from `src_addr` 0x0000.
- **Synced:** write 0x03 with vblank high. No writes occur until vblank falls and rises again; the first write comes 2 cycles after the rise.
- **Busy protection:** a second start and base writes mid-transfer are ignored. Status read mid-transfer = 0x01; after completion = 0x02; an immediate re-read = 0x00.
- **Reset mid-op:** assert `reset` at write 50. Required: no further writes, busy=0, status 0x00, no `done_irq`.
- **Abort (macro on):** vblank falls at write 40 of a synced transfer. Required: no writes after C, status 0x06, and one `done_irq` pulse.
